// File: rtl/display_timings.sv
// Raster timing generator: scans an H_TOTAL x V_TOTAL grid on the pixel clock.
// It emits registered coordinates, syncs, data-enable and line/frame strobes.
// Every output is decoded from the same (h,v) on the same edge, so there is no skew.
module display_timings #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int H_POL  = 0,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int V_POL  = 0
) (
    input  logic        i_pix_clk,
    input  logic        i_rst,
    output logic [15:0] o_sx,
    output logic [15:0] o_sy,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic        o_line,
    output logic        o_frame
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Region bounds are held at 17 bits: a sync that ends exactly at a
    // 65536 total would not fit in 16.
    localparam logic [16:0] H_ACT_END  = 17'(H_RES);
    localparam logic [16:0] H_SYNC_BEG = 17'(H_RES + H_FP);
    localparam logic [16:0] H_SYNC_END = 17'(H_RES + H_FP + H_SYNC);
    localparam logic [16:0] V_ACT_END  = 17'(V_RES);
    localparam logic [16:0] V_SYNC_BEG = 17'(V_RES + V_FP);
    localparam logic [16:0] V_SYNC_END = 17'(V_RES + V_FP + V_SYNC);

    // Wrap points are the last legal position, so the 16-bit counters
    // never need to represent the total itself.
    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

    localparam logic HS_ON = 1'(H_POL);
    localparam logic VS_ON = 1'(V_POL);

    logic [15:0] h;
    logic [15:0] v;
    logic [16:0] h_x;
    logic [16:0] v_x;

    logic hs_act;
    logic vs_act;
    logic de_nxt;
    logic line_nxt;
    logic frame_nxt;

    assign h_x = {1'b0, h};
    assign v_x = {1'b0, v};

    // Decode the current scan position into the values to register this edge.
    always_comb begin
        hs_act    = (h_x >= H_SYNC_BEG) && (h_x < H_SYNC_END);
        vs_act    = (v_x >= V_SYNC_BEG) && (v_x < V_SYNC_END);
        de_nxt    = (h_x < H_ACT_END) && (v_x < V_ACT_END);
        line_nxt  = (h == 16'd0);
        frame_nxt = (h == 16'd0) && (v == 16'd0);
    end

    // Scan counters: h runs every cycle and v steps when h wraps.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            h <= 16'd0;
            v <= 16'd0;
        end else if (h == H_LAST) begin
            h <= 16'd0;
            v <= (v == V_LAST) ? 16'd0 : v + 16'd1;
        end else begin
            h <= h + 16'd1;
        end
    end

    // Output registers; reset drives syncs to their inactive level.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_sx    <= 16'd0;
            o_sy    <= 16'd0;
            o_hs    <= ~HS_ON;
            o_vs    <= ~VS_ON;
            o_de    <= 1'b0;
            o_line  <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            o_sx    <= h;
            o_sy    <= v;
            o_hs    <= hs_act ? HS_ON : ~HS_ON;
            o_vs    <= vs_act ? VS_ON : ~VS_ON;
            o_de    <= de_nxt;
            o_line  <= line_nxt;
            o_frame <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: a default 640x480 instance and a tiny raster
// with active-high syncs. A hand-derived vector table covers the tiny raster's
// reset, first line and re-reset. A reference model then feeds a scoreboard
// queue for both instances, cycle by cycle, including mid-line resets.
module tb_display_timings;

    typedef struct packed {
        logic [15:0] sx;
        logic [15:0] sy;
        logic        hs;
        logic        vs;
        logic        de;
        logic        line;
        logic        frame;
    } out_t;

    typedef struct packed {
        logic rst;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic [15:0] a_sx, a_sy, b_sx, b_sy;
    logic a_hs, a_vs, a_de, a_line, a_frame;
    logic b_hs, b_vs, b_de, b_line, b_frame;
    out_t oa, ob;

    int checks = 0;
    int errors = 0;

    out_t qa[$];
    out_t qb[$];

    always #5 clk = ~clk;

    display_timings dut_a (
        .i_pix_clk(clk), .i_rst(rst_a),
        .o_sx(a_sx), .o_sy(a_sy), .o_hs(a_hs), .o_vs(a_vs),
        .o_de(a_de), .o_line(a_line), .o_frame(a_frame)
    );

    display_timings #(
        .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .H_POL(1),
        .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .V_POL(1)
    ) dut_b (
        .i_pix_clk(clk), .i_rst(rst_b),
        .o_sx(b_sx), .o_sy(b_sy), .o_hs(b_hs), .o_vs(b_vs),
        .o_de(b_de), .o_line(b_line), .o_frame(b_frame)
    );

    assign oa = {a_sx, a_sy, a_hs, a_vs, a_de, a_line, a_frame};
    assign ob = {b_sx, b_sy, b_hs, b_vs, b_de, b_line, b_frame};

    function automatic out_t decode(int h, int v, int hres, int hfp, int hsync,
                                    int vres, int vfp, int vsync, int hpol, int vpol);
        out_t o;
        o.sx    = 16'(h);
        o.sy    = 16'(v);
        o.hs    = (h >= hres + hfp && h < hres + hfp + hsync) ? 1'(hpol) : ~1'(hpol);
        o.vs    = (v >= vres + vfp && v < vres + vfp + vsync) ? 1'(vpol) : ~1'(vpol);
        o.de    = (h < hres) && (v < vres);
        o.line  = (h == 0);
        o.frame = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_out(int hpol, int vpol);
        out_t o;
        o = '0;
        o.hs = ~1'(hpol);
        o.vs = ~1'(vpol);
        return o;
    endfunction

    task automatic check_out(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b, expected sx=%0d sy=%0d hs=%b vs=%b de=%b line=%b frame=%b",
                     name, $time, act.sx, act.sy, act.hs, act.vs, act.de, act.line, act.frame,
                     exp.sx, exp.sy, exp.hs, exp.vs, exp.de, exp.line, exp.frame);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(string name, ref out_t q[$], input out_t act);
        out_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            e = q.pop_front();
            check_out(name, act, e);
        end
    endtask

    vec_t tbl[14];

    initial begin
        int ah, av, bh, bv;
        int hs_cnt, de_cnt, line_cnt, last_frame, frame_gaps;
        out_t e;

        // Tiny raster (H_TOTAL=8, V_TOTAL=5, active-high syncs), hand-derived.
        //              rst    sx     sy     hs    vs    de    line  frame
        tbl[0]  = {1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = {1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = {1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = {1'b0, 16'd1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = {1'b0, 16'd2, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = {1'b0, 16'd3, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = {1'b0, 16'd4, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = {1'b0, 16'd5, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = {1'b0, 16'd6, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = {1'b0, 16'd7, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = {1'b0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = {1'b0, 16'd1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = {1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = {1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 14; i++) begin
            rst_b = tbl[i].rst;
            qb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            pop_check($sformatf("tiny_vec%0d", i), qb, ob);
        end

        // Scoreboard phase: both instances are re-reset and then tracked by the model.
        ah = 0; av = 0; bh = 0; bv = 0;
        hs_cnt = 0; de_cnt = 0; line_cnt = 0;
        last_frame = -1; frame_gaps = 0;
        for (int n = 0; n < 2700; n++) begin
            // A: mid-line reset for 3 cycles at (h=300, v=1).
            rst_a = (n < 2) || (n >= 1102 && n < 1105);
            // B: one reset cycle partway through a frame.
            rst_b = (n < 2) || (n == 300);

            if (rst_a) begin
                e = rst_out(0, 0);
                ah = 0; av = 0;
            end else begin
                e = decode(ah, av, 640, 16, 96, 480, 10, 2, 0, 0);
                if (ah == 799) begin
                    ah = 0;
                    av = (av == 524) ? 0 : av + 1;
                end else begin
                    ah++;
                end
            end
            qa.push_back(e);

            if (rst_b) begin
                e = rst_out(1, 1);
                bh = 0; bv = 0;
                last_frame = -1;
            end else begin
                e = decode(bh, bv, 4, 1, 1, 2, 1, 1, 1, 1);
                if (bh == 7) begin
                    bh = 0;
                    bv = (bv == 4) ? 0 : bv + 1;
                end else begin
                    bh++;
                end
            end
            qb.push_back(e);

            @(posedge clk);
            #1;
            pop_check("sb_default", qa, oa);
            pop_check("sb_tiny", qb, ob);

            // Line 0 of the default raster occupies edges n=2..801.
            if (n >= 2 && n < 802) begin
                if (a_hs == 1'b0) hs_cnt++;
                if (a_de) de_cnt++;
            end
            if (n >= 2 && n < 1102 && a_line) line_cnt++;

            if (!rst_b && b_frame) begin
                if (last_frame >= 0) begin
                    check_int("tiny_frame_period", n - last_frame, 40);
                    frame_gaps++;
                end
                last_frame = n;
            end
        end

        check_int("line0_hs_active_cycles", hs_cnt, 96);
        check_int("line0_de_cycles", de_cnt, 640);
        check_int("line_strobes_before_reset", line_cnt, 2);
        check_int("tiny_frame_gaps_seen", (frame_gaps > 0) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
